// File: rtl/tick_arbiter_pkg.sv
// Shared types and constants for the tick scheduler and related
// shared-resource schedulers.
package tick_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_DIV = 32'd1;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_arbiter_if.sv
// Config and request/tick bundle between the cores and the tick scheduler.
interface tick_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32
);
  localparam int IDW = tick_pkg::idw(NUM_REQ);

  logic               cfg_we;
  logic [CNT_W-1:0]   cfg_div;
  logic               cfg_busy;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] tick;
  logic [IDW-1:0]     tick_id;

  modport master (
    output cfg_we, cfg_div, req,
    input  cfg_busy, tick, tick_id
  );

  modport slave (
    input  cfg_we, cfg_div, req,
    output cfg_busy, tick, tick_id
  );
endinterface

// File: rtl/tick_arbiter_rr.sv
// Combinational round-robin pick: first set request above last_i, wrapping.
module tick_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = tick_pkg::idw(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               valid_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    // i == NUM_REQ revisits last_i itself, so it has the lowest priority
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(last_i) + i) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/tick_arbiter.sv
// Round-robin tick scheduler: one shared divider, one-hot single-cycle
// clock-enable pulses, ratio changes applied only on tick boundaries.
module tick_arbiter #(
  parameter int               NUM_REQ     = 4,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(tick_pkg::DEFAULT_DIV)
)(
  input logic           inclk,
  input logic           rst,
  tick_arbiter_if.slave bus
);
  import tick_pkg::*;

  localparam int IDW = idw(NUM_REQ);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               busy_q, busy_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0] tick_q, tick_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [IDW-1:0]     grant_idx_s;
  logic               grant_vld_s;

  tick_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .req_i   (bus.req),
    .last_i  (last_q),
    .grant_o (grant_s),
    .idx_o   (grant_idx_s),
    .valid_o (grant_vld_s)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    last_d  = last_q;
    id_d    = id_q;
    tick_d  = '0;
    case (state_q)
      COUNT: begin
        count_d = count_q + CNT_W'(1);
        state_d = (count_d == div_q) ? READY : COUNT;
        if (bus.cfg_we) begin
          pend_d = bus.cfg_div;
          busy_d = 1'b1;
        end else begin
          busy_d = busy_q;
        end
      end
      READY: begin
        if (grant_vld_s) begin
          tick_d  = grant_s;
          id_d    = grant_idx_s;
          last_d  = grant_idx_s;
          count_d = '0;
          busy_d  = 1'b0;
          // A write on the fire edge beats an older pending value
          if (bus.cfg_we) begin
            div_d = bus.cfg_div;
          end else if (busy_q) begin
            div_d = pend_q;
          end else begin
            div_d = div_q;
          end
          state_d = (div_d == '0) ? READY : COUNT;
        end else if (bus.cfg_we) begin
          div_d   = bus.cfg_div;
          count_d = '0;
          busy_d  = 1'b0;
          state_d = (bus.cfg_div == '0) ? READY : COUNT;
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = COUNT;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      state_q <= COUNT;
      count_q <= '0;
      div_q   <= DEFAULT_DIV;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= IDW'(NUM_REQ - 1);
      id_q    <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      id_q    <= id_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.tick_id  = id_q;
  assign bus.cfg_busy = busy_q;

endmodule
